// File: rtl/wb_master_if.sv
// CPU-side Wishbone master adapter: turns one CPU memory request into a held bus
// transaction, stalls the pipeline until ack, buffers read data and times out hung slaves.
module wb_master_if #(
    parameter int unsigned STALL_BIT   = 3,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall_i,
    input  logic        flush_i,
    input  logic        cpu_ce_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_data_i,
    input  logic        cpu_we_i,
    input  logic [3:0]  cpu_sel_i,
    output logic [31:0] cpu_data_o,
    output logic        stallreq_o,
    output logic        bus_err_o,
    output logic [31:0] wishbone_addr_o,
    output logic [31:0] wishbone_data_o,
    output logic        wishbone_we_o,
    output logic [3:0]  wishbone_select_o,
    input  logic [31:0] wishbone_data_i,
    input  logic        wishbone_ack_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_WAIT_STALL
    } state_e;

    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYC);

    state_e      state_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic        we_q;
    logic [3:0]  sel_q;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        drop_q;
    logic [31:0] rd_buf_q;

    logic start;
    logic ack_live;
    logic timeout;
    logic stage_stalled;

    // Only the stall bit of the stage this port serves matters.
    logic unused_stall;
    assign unused_stall  = ^stall_i;
    assign stage_stalled = stall_i[STALL_BIT];

    assign start    = (state_q == S_IDLE) && cpu_ce_i && !flush_i;
    assign ack_live = (state_q == S_BUSY) && wishbone_ack_i && !drop_q;
    // An ack arriving in the limit cycle wins over the timeout.
    assign timeout  = (state_q == S_BUSY) && !wishbone_ack_i && (cnt_q == TIMEOUT_LIM);
    assign cnt_d    = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    assign wishbone_addr_o   = addr_q;
    assign wishbone_data_o   = data_q;
    assign wishbone_we_o     = we_q;
    assign wishbone_select_o = sel_q;
    assign bus_err_o         = timeout;

    always_comb begin
        stallreq_o = 1'b0;
        cpu_data_o = 32'h0;
        case (state_q)
            S_IDLE:       stallreq_o = start;
            S_BUSY:       stallreq_o = !timeout && (!wishbone_ack_i || drop_q);
            S_WAIT_STALL: cpu_data_o = rd_buf_q;
            default:      stallreq_o = 1'b0;
        endcase
        if (ack_live && !we_q) begin
            cpu_data_o = wishbone_data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; the async reset clears the bus outputs the instant rst falls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            addr_q   <= 32'h0;
            data_q   <= 32'h0;
            we_q     <= 1'b0;
            sel_q    <= 4'h0;
            cnt_q    <= 16'h0;
            drop_q   <= 1'b0;
            rd_buf_q <= 32'h0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        addr_q  <= cpu_addr_i;
                        data_q  <= cpu_data_i;
                        we_q    <= cpu_we_i;
                        sel_q   <= cpu_sel_i;
                        cnt_q   <= 16'h0;
                        drop_q  <= 1'b0;
                        state_q <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    cnt_q <= cnt_d;
                    if (flush_i) begin
                        drop_q <= 1'b1;
                    end
                    if (wishbone_ack_i || (cnt_q == TIMEOUT_LIM)) begin
                        addr_q <= 32'h0;
                        data_q <= 32'h0;
                        we_q   <= 1'b0;
                        sel_q  <= 4'h0;
                    end
                    if (wishbone_ack_i) begin
                        if (!drop_q) begin
                            rd_buf_q <= we_q ? 32'h0 : wishbone_data_i;
                            state_q  <= stage_stalled ? S_WAIT_STALL : S_IDLE;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else if (cnt_q == TIMEOUT_LIM) begin
                        state_q <= S_IDLE;
                    end
                end
                S_WAIT_STALL: begin
                    if (flush_i || !stage_stalled) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/wb_master_if.md
# wb_master_if

CPU-side Wishbone master adapter. It sits between the CPU pipeline's memory stage (or instruction fetch) and `bus_top`. It turns a CPU memory request into a single held Wishbone transaction and stalls the pipeline until `ack` arrives. It also buffers the read data across pipeline stalls, drops results cancelled by a flush, and times out hung slaves.

## Interface
Parameters:
- `STALL_BIT`, default 3: index into `stall_i` of the stage this port serves. 3 is MEM; use 1 for IF.
- `TIMEOUT_CYC`, default 1023: number of BUSY cycles without `ack` before the transaction is aborted. Legal range is 1..65535.

Ports:
- `clk`, in, 1: sole clock. Everything is rising-edge.
- `rst`, in, 1: asynchronous, active-low reset. `rst`=0 resets the block immediately; release is sampled on `clk`.
- `stall_i`, in, 6: pipeline stall vector.
- `flush_i`, in, 1: pipeline flush.
- `cpu_ce_i`, in, 1: CPU request valid.
- `cpu_addr_i`, in, 32: request byte address.
- `cpu_data_i`, in, 32: write data.
- `cpu_we_i`, in, 1: 1 = write, 0 = read.
- `cpu_sel_i`, in, 4: byte-lane enables.
- `cpu_data_o`, out, 32: read data returned to the CPU.
- `stallreq_o`, out, 1: stall request to the pipeline controller.
- `bus_err_o`, out, 1: one-cycle pulse when a transaction times out.
- `wishbone_addr_o`, out, 32: to `bus_top` `wishbone_addr_i`.
- `wishbone_data_o`, out, 32: to `wishbone_data_i`.
- `wishbone_we_o`, out, 1: to `wishbone_we_i`.
- `wishbone_select_o`, out, 4: to `wishbone_select_i`.
- `wishbone_data_i`, in, 32: from `wishbone_data_o`.
- `wishbone_ack_i`, in, 1: from `wishbone_ack_o`.

## Operation
- The bus has no strobe or cycle signal. A transaction is active exactly while `wishbone_select_o` is non-zero. Outside BUSY, all `wishbone_*_o` outputs are 0.
- The state machine has three states: IDLE, BUSY and WAIT_STALL.
- **IDLE**
  - If `cpu_ce_i`=1 and `flush_i`=0: register addr, data, we and sel into the bus outputs, clear the timeout counter, clear `drop`, and go to BUSY.
  - In that same cycle, `stallreq_o`=1.
  - Otherwise `stallreq_o`=0.
- **BUSY**
  - The bus outputs are held stable.
  - `stallreq_o` = NOT(`wishbone_ack_i`) OR `drop`.
  - `flush_i`=1 sets `drop`. The transaction is not aborted, because the slave may already be writing. It runs to `ack`, and its result is discarded.
  - On `wishbone_ack_i`=1 with `drop`=0:
    - `cpu_data_o` = `wishbone_data_i` combinationally in that cycle, and the value is captured into `rd_buf`.
    - If `stall_i[STALL_BIT]`=1, go to WAIT_STALL; otherwise go to IDLE.
  - On `wishbone_ack_i`=1 with `drop`=1: go to IDLE. `cpu_data_o`=0.
  - Counter reaches `TIMEOUT_CYC` without `ack`:
    - clear the bus outputs and go to IDLE;
    - pulse `bus_err_o` for 1 cycle;
    - `cpu_data_o`=0 and `stallreq_o`=0 in that cycle.
- **WAIT_STALL**
  - `cpu_data_o` = `rd_buf` and `stallreq_o`=0.
  - `flush_i`=1 goes to IDLE.
  - When `stall_i[STALL_BIT]`=0, go to IDLE.
- Write transactions return `cpu_data_o`=0.
- In IDLE, `cpu_data_o`=0.
- Timeout counter:
  - 16 bits, increments each BUSY cycle and saturates.
  - Compared with `==TIMEOUT_CYC`.
- Simultaneous `ack` and timeout in the same cycle: `ack` wins and there is no `bus_err_o`.

## Timing
- Reset values: all registered outputs 0; state=IDLE; `rd_buf`=0; `drop`=0. As a result `stallreq_o`=0, `cpu_data_o`=0, `bus_err_o`=0 and `wishbone_select_o`=0.
- Reset asserted mid-transaction: the bus outputs drop to 0 asynchronously, and the request is lost.
- Latency:
  - The request is presented in cycle N (IDLE). The bus outputs are valid from N+1.
  - With a slave `ack` at N+k (k≥1), the data is on `cpu_data_o` at N+k. `stallreq_o` is high for cycles N..N+k-1 and low at N+k.
  - Minimum read latency is 2 cycles.
- A new request cannot start in the same cycle as an `ack`. The earliest back-to-back bus transaction is 2 cycles after the previous `ack` edge.
- `bus_err_o` is high in exactly the cycle state leaves BUSY on timeout, i.e. BUSY cycle `TIMEOUT_CYC`+1.

## Test plan
- **Read, 1-cycle ack.** Request read at 0x0000_0100, sel=4'hF; slave acks in the first BUSY cycle with 0xDEAD_BEEF.
  - `stallreq_o` is high for exactly 1 cycle.
  - `cpu_data_o`=0xDEAD_BEEF in the `ack` cycle.
  - Outputs return to 0 next cycle.
- **Write, 3-cycle ack.** Write 0x1234_5678 to 0x0000_0200, sel=4'b0011; `ack` on the 3rd BUSY cycle.
  - Bus outputs are stable for 3 cycles; `wishbone_we_o`=1.
  - `stallreq_o` is high for 3 cycles (IDLE cycle + 2 BUSY cycles), then 0.
  - `cpu_data_o`=0.
- **Read under pipeline stall.** Read ack 0xCAFE_0001 while `stall_i[3]`=1, which stays high 4 more cycles.
  - `cpu_data_o` holds 0xCAFE_0001 all 4 cycles.
  - IDLE is entered the cycle after `stall_i[3]` falls.
- **Flush mid-transaction.** Assert `flush_i` in BUSY cycle 1; slave acks in cycle 4 with 0xFFFF_FFFF.
  - Bus outputs are held through cycle 4.
  - `cpu_data_o` stays 0.
  - `stallreq_o` is high until `ack`, then IDLE.
- **Timeout.** `TIMEOUT_CYC`=8, the slave never acks.
  - `bus_err_o` is a 1-cycle pulse at BUSY cycle 9.
  - `wishbone_select_o`=0 afterwards and `stallreq_o`=0.
  - A following request completes normally.
- **Async reset.** Drop `rst` to 0 between clock edges while BUSY.
  - All outputs are 0 immediately.
  - After release, a read completes with correct data.
